// File: rtl/change_dispenser.sv
// Greedy change payout engine: pays `cambio` units as 5/2/1 coins over a valid/ack handshake.
// Define CAMBIO_INVENTORY_EN to add per-denomination stock counters, refill and shortfall reporting.
module change_dispenser #(
  parameter int INIT_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cambio,
  input  logic       load,
  input  logic       coin_ack,
  input  logic       refill,
  output logic       coin_valid,
  output logic [1:0] coin_code,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [3:0] remaining
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

  localparam logic [3:0] INIT = 4'(INIT_COUNT);

  state_t     state;
  logic [1:0] pick;
  logic [3:0] coin_value;
  logic       ok1, ok2, ok5;

`ifdef CAMBIO_INVENTORY_EN
  // stock[0] = 1-unit, stock[1] = 2-unit, stock[2] = 5-unit (index = coin code - 1)
  logic [3:0] stock [3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) stock[i] <= INIT;
    end else if (state == IDLE && refill) begin
      for (int i = 0; i < 3; i++) stock[i] <= INIT;
    end else if (state == ISSUE && coin_ack) begin
      for (int i = 0; i < 3; i++)
        if (coin_code == 2'(i + 1) && stock[i] != 4'd0) stock[i] <= stock[i] - 4'd1;
    end
  end

  assign ok1 = (stock[0] != 4'd0);
  assign ok2 = (stock[1] != 4'd0);
  assign ok5 = (stock[2] != 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      short <= 1'b0;
    else if (state == IDLE && load)
      short <= 1'b0;
    else if (state == SELECT && pick == 2'b00 && remaining != 4'd0)
      short <= 1'b1;
  end
`else
  assign ok1   = 1'b1;
  assign ok2   = 1'b1;
  assign ok5   = 1'b1;
  assign short = 1'b0;
`endif

  // Greedy choice: largest coin that fits the amount owed and is in stock
  always_comb begin
    pick = 2'b00;
    if (remaining >= 4'd5 && ok5)
      pick = 2'b11;
    else if (remaining >= 4'd2 && ok2)
      pick = 2'b10;
    else if (remaining >= 4'd1 && ok1)
      pick = 2'b01;
  end

  always_comb begin
    case (coin_code)
      2'b11:   coin_value = 4'd5;
      2'b10:   coin_value = 4'd2;
      2'b01:   coin_value = 4'd1;
      default: coin_value = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      coin_valid <= 1'b0;
      coin_code  <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            remaining <= cambio;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (pick != 2'b00) begin
            coin_code  <= pick;
            coin_valid <= 1'b1;
            state      <= ISSUE;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        ISSUE: begin
          if (coin_ack) begin
            remaining  <= remaining - coin_value;
            coin_valid <= 1'b0;
            coin_code  <= 2'b00;
            state      <= SELECT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised bench for change_dispenser: greedy-plan reference model plus per-cycle output compare.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int TB_INIT = 2;
`ifdef CAMBIO_INVENTORY_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cambio = 4'd0;
  logic       load = 1'b0;
  logic       coin_ack = 1'b0;
  logic       refill = 1'b0;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       busy;
  logic       done;
  logic       short;
  logic [3:0] remaining;

  change_dispenser #(.INIT_COUNT(TB_INIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cambio     (cambio),
    .load       (load),
    .coin_ack   (coin_ack),
    .refill     (refill),
    .coin_valid (coin_valid),
    .coin_code  (coin_code),
    .busy       (busy),
    .done       (done),
    .short      (short),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int st [3] = '{TB_INIT, TB_INIT, TB_INIT};
  int plan [$];
  int m_busy = 0, m_valid = 0, m_code = 0, m_done = 0, m_short = 0, m_rem = 0;

  // Whole payout decided up front: greedy over the stock that exists at load time
  task automatic build_plan(input int c, input bit commit);
    int r;
    int s [3];
    int k;
    r = c;
    s = st;
    plan.delete();
    while (1) begin
      if (r >= 5 && (!INV || s[2] > 0)) k = 2;
      else if (r >= 2 && (!INV || s[1] > 0)) k = 1;
      else if (r >= 1 && (!INV || s[0] > 0)) k = 0;
      else break;
      plan.push_back(k + 1);
      r -= (k == 2) ? 5 : k + 1;
      s[k]--;
    end
    if (commit) st = s;
  endtask

  function automatic int plan_sig();
    int sig;
    sig = 0;
    foreach (plan[i]) sig = sig * 10 + plan[i];
    return sig;
  endfunction

  function automatic int value_of(input int code);
    case (code)
      3: return 5;
      2: return 2;
      1: return 1;
      default: return 0;
    endcase
  endfunction

  initial forever begin
    int was_done;
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_busy = 0; m_valid = 0; m_code = 0; m_done = 0; m_short = 0; m_rem = 0;
      plan.delete();
      st = '{TB_INIT, TB_INIT, TB_INIT};
    end else begin
      was_done = m_done;
      m_done = 0;
      if (m_busy == 0) begin
        if (refill && INV) st = '{TB_INIT, TB_INIT, TB_INIT};
        if (load) begin
          build_plan(int'(cambio), 1'b1);
          m_rem = int'(cambio);
          m_short = 0;
          m_busy = 1;
        end
      end else if (was_done != 0) begin
        m_busy = 0;
      end else if (m_valid != 0) begin
        if (coin_ack) begin
          m_rem -= value_of(m_code);
          m_valid = 0;
          m_code = 0;
        end
      end else if (plan.size() > 0) begin
        m_valid = 1;
        m_code = plan.pop_front();
      end else begin
        m_done = 1;
        m_short = (m_rem != 0) ? 1 : 0;
      end
    end
  end

  // ---------------- compare + observation ----------------
  int acc_cnt = 0, acc_sig = 0, valid_cycles = 0, busy_cycles = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("coin_valid", int'(coin_valid), m_valid);
      chk("coin_code", int'(coin_code), m_code);
      chk("busy", int'(busy), m_busy);
      chk("done", int'(done), m_done);
      chk("short", int'(short), m_short);
      chk("remaining", int'(remaining), m_rem);
      if (coin_valid) valid_cycles++;
      if (busy) busy_cycles++;
      if (coin_valid && coin_ack) begin
        acc_cnt++;
        acc_sig = acc_sig * 10 + int'(coin_code);
      end
    end
  end

  // ---------------- hopper ----------------
  int ack_delay = 1;
  int vcnt = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (coin_valid) vcnt++;
    else vcnt = 0;
    if (ack_delay > 0) coin_ack = (vcnt == ack_delay);
    else coin_ack = ($urandom_range(0, 2) == 0);
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic run_txn(input int c, input bit noise);
    int t;
    bit got_done;
    wait_idle();
    @(posedge clk);
    #1;
    acc_cnt = 0; acc_sig = 0; valid_cycles = 0; busy_cycles = 0;
    cambio = 4'(c);
    load = 1'b1;
    refill = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
    t = 0;
    got_done = 1'b0;
    do begin
      @(posedge clk);
      #1;
      load   = noise && ($urandom_range(0, 3) == 0);
      refill = noise && ($urandom_range(0, 3) == 0);
      cambio = 4'($urandom);
      @(negedge clk);
      t++;
      if (done) got_done = 1'b1;
    end while (!got_done && t < 300);
    chk("done_timeout", int'(got_done), 1);
    @(posedge clk);
    #1;
    load = 1'b0;
    refill = 1'b0;
    $display("txn cambio=%0d coins=%0d seq=%0d remaining=%0d short=%0b", c, acc_cnt, acc_sig,
             remaining, short);
  endtask

  initial begin
    int t;
    // Model pins: greedy plans worked out by hand
    build_plan(8, 1'b0); chk("pin_plan8", plan_sig(), 321);
    build_plan(9, 1'b0); chk("pin_plan9", plan_sig(), 322);
    build_plan(7, 1'b0); chk("pin_plan7", plan_sig(), 32);
    build_plan(4, 1'b0); chk("pin_plan4", plan_sig(), 22);
    build_plan(0, 1'b0); chk("pin_plan0", plan_sig(), 0);

    #22 reset = 1'b1;
    @(negedge clk);
    chk("rst_coin_valid", int'(coin_valid), 0);
    chk("rst_coin_code", int'(coin_code), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short", int'(short), 0);
    chk("rst_remaining", int'(remaining), 0);

    ack_delay = 1;
    run_txn(8, 1'b0);
    chk("c8_seq", acc_sig, 321);
    chk("c8_count", acc_cnt, 3);
    chk("c8_remaining", int'(remaining), 0);
    chk("c8_short", int'(short), 0);

    run_txn(0, 1'b0);
    chk("c0_coins", acc_cnt, 0);
    chk("c0_busy_cycles", busy_cycles, 2);

    ack_delay = 5;
    run_txn(5, 1'b0);
    chk("c5_count", acc_cnt, 1);
    chk("c5_seq", acc_sig, 3);
    chk("c5_hold_cycles", valid_cycles, 5);

    ack_delay = 0;
    run_txn(9, 1'b1);

    // Reset while a coin is presented
    ack_delay = 20;
    wait_idle();
    @(posedge clk);
    #1;
    cambio = 4'd15;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    t = 0;
    while (!coin_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rstmid_valid_seen", int'(coin_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_valid_drop", int'(coin_valid), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_remaining", int'(remaining), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    ack_delay = 1;
    run_txn(8, 1'b0);
    chk("post_rst_seq", acc_sig, 321);

    for (int n = 0; n < 40; n++) begin
      ack_delay = $urandom_range(0, 3);
      run_txn($urandom_range(0, 15), $urandom_range(0, 1) == 1);
    end

    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
